// File: rtl/smash_vc_fifo.sv
// rtl/smash_vc_fifo.sv - multi-VC router input FIFO sharing one storage array
// Per-VC counts drive all flags, so every one of the DEPTH slots is usable.
module smash_vc_fifo #(
   parameter int ADDR_SIZE = 2,
   parameter int DATA_SIZE = 32,
   parameter int NUM_VC    = 2,
   parameter int VC_BITS   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   parameter int AF_LEVEL  = 3
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [DATA_SIZE-1:0]            i_data,
   input  logic                            i_write,
   input  logic [VC_BITS-1:0]              i_write_vc,
   input  logic                            i_read,
   input  logic [VC_BITS-1:0]              i_read_vc,
   output logic [DATA_SIZE-1:0]            o_data,
   output logic [NUM_VC-1:0]               o_full,
   output logic [NUM_VC-1:0]               o_empty,
   output logic [NUM_VC-1:0]               o_almost_full,
   output logic [NUM_VC*(ADDR_SIZE+1)-1:0] o_count,
   output logic                            o_overflow,
   output logic                            o_underflow
);
   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam int CW    = ADDR_SIZE + 1;
   localparam int MAW   = $clog2(NUM_VC * DEPTH);
   localparam logic [VC_BITS:0] NVC = (VC_BITS+1)'(NUM_VC);

   logic [DATA_SIZE-1:0] r_mem [NUM_VC*DEPTH];
   logic [ADDR_SIZE-1:0] r_wr_ptr [NUM_VC];
   logic [ADDR_SIZE-1:0] r_rd_ptr [NUM_VC];
   logic [CW-1:0]        r_count  [NUM_VC];
   logic                 r_overflow;
   logic                 r_underflow;

   logic [VC_BITS-1:0]           w_wvc;
   logic [VC_BITS-1:0]           w_rvc;
   logic                         w_wvc_ok;
   logic                         w_rvc_ok;
   logic [NUM_VC-1:0]            w_we_v;
   logic [NUM_VC-1:0]            w_re_v;
   logic                         w_we;
   logic                         w_ovf_evt;
   logic                         w_unf_evt;
   logic                         w_rhit;
   logic [VC_BITS+ADDR_SIZE-1:0] w_waddr;
   logic [VC_BITS+ADDR_SIZE-1:0] w_raddr;

   // With a single VC the index inputs carry no meaning and are forced to zero.
   assign w_wvc    = (NUM_VC == 1) ? '0 : i_write_vc;
   assign w_rvc    = (NUM_VC == 1) ? '0 : i_read_vc;
   assign w_wvc_ok = ({1'b0, w_wvc} < NVC);
   assign w_rvc_ok = ({1'b0, w_rvc} < NVC);

   always_comb begin
      o_full        = '0;
      o_empty       = '0;
      o_almost_full = '0;
      o_count       = '0;
      w_we_v        = '0;
      w_re_v        = '0;
      w_ovf_evt     = 1'b0;
      w_unf_evt     = 1'b0;
      w_rhit        = 1'b0;
      w_waddr       = '0;
      w_raddr       = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         o_full[v]            = (r_count[v] == CW'(DEPTH));
         o_empty[v]           = (r_count[v] == '0);
         o_almost_full[v]     = (r_count[v] >= CW'(AF_LEVEL));
         o_count[v*CW +: CW]  = r_count[v];
         if (i_write && w_wvc_ok && (w_wvc == VC_BITS'(v))) begin
            w_we_v[v] = !o_full[v];
            w_ovf_evt = o_full[v];
            w_waddr   = {VC_BITS'(v), r_wr_ptr[v]};
         end
         if (i_read && w_rvc_ok && (w_rvc == VC_BITS'(v))) begin
            w_re_v[v] = !o_empty[v];
            w_unf_evt = o_empty[v];
         end
         if (w_rvc_ok && (w_rvc == VC_BITS'(v))) begin
            w_rhit  = !o_empty[v];
            w_raddr = {VC_BITS'(v), r_rd_ptr[v]};
         end
      end
      w_we   = |w_we_v;
      o_data = w_rhit ? r_mem[w_raddr[MAW-1:0]] : '0;
   end

   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[w_waddr[MAW-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_wr_ptr[v] <= '0;
            r_rd_ptr[v] <= '0;
            r_count[v]  <= '0;
         end
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (w_we_v[v]) r_wr_ptr[v] <= r_wr_ptr[v] + 1'b1;
            if (w_re_v[v]) r_rd_ptr[v] <= r_rd_ptr[v] + 1'b1;
            if (w_we_v[v] && !w_re_v[v])      r_count[v] <= r_count[v] + CW'(1);
            else if (w_re_v[v] && !w_we_v[v]) r_count[v] <= r_count[v] - CW'(1);
         end
         if (w_ovf_evt) r_overflow  <= 1'b1;
         if (w_unf_evt) r_underflow <= 1'b1;
      end
   end

   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;
endmodule

// File: tb/tb_smash_vc_fifo.sv
// tb/tb_smash_vc_fifo.sv - directed self-checking bench for smash_vc_fifo
module tb_smash_vc_fifo;
   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_data;
   logic        i_write;
   logic [0:0]  i_write_vc;
   logic        i_read;
   logic [0:0]  i_read_vc;
   logic [31:0] o_data;
   logic [1:0]  o_full;
   logic [1:0]  o_empty;
   logic [1:0]  o_almost_full;
   logic [5:0]  o_count;
   logic        o_overflow;
   logic        o_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   smash_vc_fifo dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_data        (i_data),
      .i_write       (i_write),
      .i_write_vc    (i_write_vc),
      .i_read        (i_read),
      .i_read_vc     (i_read_vc),
      .o_data        (o_data),
      .o_full        (o_full),
      .o_empty       (o_empty),
      .o_almost_full (o_almost_full),
      .o_count       (o_count),
      .o_overflow    (o_overflow),
      .o_underflow   (o_underflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic cyc(input logic w, input logic [0:0] wvc, input logic [31:0] d,
                      input logic r, input logic [0:0] rvc);
      i_write    = w;
      i_write_vc = wvc;
      i_data     = d;
      i_read     = r;
      i_read_vc  = rvc;
      tick();
      i_write = 1'b0;
      i_read  = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [0:0] vc, input logic [31:0] exp);
      i_read_vc = vc;
      #1;
      check(tag, o_data, exp);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, vc);
   endtask

   initial begin
      i_rst_n = 1'b0; i_data = '0; i_write = 1'b0; i_write_vc = '0;
      i_read = 1'b0; i_read_vc = '0;
      tick(); tick();
      check("rst_empty", o_empty, 2'b11);
      check("rst_full", o_full, 2'b00);
      check("rst_af", o_almost_full, 2'b00);
      check("rst_count", o_count, 6'd0);
      check("rst_ovf", o_overflow, 1'b0);
      check("rst_unf", o_underflow, 1'b0);
      i_rst_n = 1'b1;

      // fill VC0
      cyc(1'b1, 1'b0, 32'hA0, 1'b0, 1'b0);
      check("fill1_cnt", o_count[2:0], 3'd1);
      cyc(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
      check("fill2_af", o_almost_full, 2'b00);
      cyc(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0);
      check("fill3_af", o_almost_full, 2'b01);
      check("fill3_full", o_full, 2'b00);
      cyc(1'b1, 1'b0, 32'hA3, 1'b0, 1'b0);
      check("fill4_full", o_full, 2'b01);
      check("fill4_cnt", o_count, 6'b000_100);
      check("fill_head", o_data, 32'hA0);

      // drain with pointer wrap
      pop("pop_a0", 1'b0, 32'hA0);
      pop("pop_a1", 1'b0, 32'hA1);
      cyc(1'b1, 1'b0, 32'hB0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 32'hB1, 1'b0, 1'b0);
      check("refill_cnt", o_count[2:0], 3'd4);
      pop("pop_a2", 1'b0, 32'hA2);
      pop("pop_a3", 1'b0, 32'hA3);
      pop("pop_b0", 1'b0, 32'hB0);
      pop("pop_b1", 1'b0, 32'hB1);
      check("drain_empty", o_empty, 2'b11);
      check("drain_data0", o_data, 32'h0);

      // overflow / underflow
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'hE0 + i, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 32'hFF, 1'b0, 1'b0);
      check("ovf_flag", o_overflow, 1'b1);
      check("ovf_cnt", o_count[2:0], 3'd4);
      check("ovf_unf_clr", o_underflow, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      check("unf_flag", o_underflow, 1'b1);
      check("unf_cnt1", o_count[5:3], 3'd0);
      for (int i = 0; i < 10; i++) tick();
      check("ovf_sticky", o_overflow, 1'b1);
      check("unf_sticky", o_underflow, 1'b1);

      // simultaneous read/write on full VC0: write dropped, head popped
      i_read_vc = 1'b0;
      #1;
      check("simf_head", o_data, 32'hE0);
      cyc(1'b1, 1'b0, 32'hC0, 1'b1, 1'b0);
      check("simf_cnt", o_count[2:0], 3'd3);
      check("simf_next", o_data, 32'hE1);
      pop("pop_e1", 1'b0, 32'hE1);
      i_read_vc = 1'b0;
      #1;
      check("sim2_head", o_data, 32'hE2);
      cyc(1'b1, 1'b0, 32'hC0, 1'b1, 1'b0);
      check("sim2_cnt", o_count[2:0], 3'd2);
      pop("pop_e3", 1'b0, 32'hE3);
      pop("pop_c0", 1'b0, 32'hC0);
      check("sim2_empty", o_empty, 2'b11);

      // cross-VC independence
      cyc(1'b1, 1'b0, 32'h21, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 32'h22, 1'b0, 1'b0);
      i_read_vc = 1'b0;
      #1;
      check("xvc_head", o_data, 32'h21);
      cyc(1'b1, 1'b1, 32'h11, 1'b1, 1'b0);
      check("xvc_cnt", o_count, 6'b001_001);
      check("xvc_vc0", o_data, 32'h22);
      i_read_vc = 1'b1;
      #1;
      check("xvc_vc1", o_data, 32'h11);

      // asynchronous reset away from any clock edge
      #1;
      i_rst_n = 1'b0;
      #1;
      check("arst_empty", o_empty, 2'b11);
      check("arst_count", o_count, 6'd0);
      check("arst_ovf", o_overflow, 1'b0);
      check("arst_unf", o_underflow, 1'b0);
      check("arst_data", o_data, 32'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;

      // simultaneous read/write on empty VC1: read dropped, write kept
      cyc(1'b1, 1'b1, 32'hD0, 1'b1, 1'b1);
      check("sime_cnt", o_count, 6'b001_000);
      check("sime_unf", o_underflow, 1'b1);
      check("sime_ovf", o_overflow, 1'b0);
      check("sime_data", o_data, 32'hD0);
      check("sime_empty", o_empty, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
